// File: rtl/decode_6466b_if.sv
// Block-side and XGMII-side signal bundle for the 64b/66b receive decoder.
// The master modport belongs to whatever feeds blocks in and consumes words out;
// the slave modport belongs to the decoder itself.
interface decode_6466b_if #(
  parameter int ERR_CNT_WIDTH = 16
);
  logic                     i_block_lock;
  logic                     i_rx_valid;
  logic [63:0]              i_rxd;
  logic [1:0]               i_rx_header;
  logic                     i_err_clear;
  logic [31:0]              o_rxd;
  logic [3:0]               o_rxctl;
  logic                     o_rx_valid;
  logic [ERR_CNT_WIDTH-1:0] o_err_count;

  modport master (
    output i_block_lock, i_rx_valid, i_rxd, i_rx_header, i_err_clear,
    input  o_rxd, o_rxctl, o_rx_valid, o_err_count
  );

  modport slave (
    input  i_block_lock, i_rx_valid, i_rxd, i_rx_header, i_err_clear,
    output o_rxd, o_rxctl, o_rx_valid, o_err_count
  );
endinterface

// File: rtl/decode_6466b.sv
// Receive-side 64b/66b decoder. Classifies each descrambled 66-bit block,
// runs the Clause 49 receive state machine and emits the block as two 32-bit
// XGMII words (lanes 0-3, then lanes 4-7) on consecutive cycles. Blocks that
// drive the FSM into RX_E are replaced by error words and counted.
module decode_6466b #(
  parameter int ERR_CNT_WIDTH = 16
) (
  input logic           i_rxc,
  input logic           i_reset_n,
  decode_6466b_if.slave bus
);

  typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} rxState_e;
  typedef enum logic [2:0] {R_C, R_S, R_D, R_T, R_E} rType_e;

  localparam logic [31:0] IDLE_WORD = 32'h0707_0707;
  localparam logic [31:0] ERR_WORD  = 32'hFEFE_FEFE;
  localparam logic [31:0] LF_WORD   = 32'h0100_009C;

  rxState_e                 state_q, state_d;
  rType_e                   rType;
  logic [63:0]              decData;
  logic [7:0]               decCtl;
  logic [63:0]              outData_d;
  logic [7:0]               outCtl_d;
  logic [31:0]              rxd_q, upperRxd_q;
  logic [3:0]               rxctl_q, upperCtl_q;
  logic                     rxValid_q, upperPending_q;
  logic [ERR_CNT_WIDTH-1:0] errCount_q;
  logic [7:0]               codeIdle, codeOk;
  logic [63:0]              termData;
  logic [3:0]               termLane;
  logic                     isTerm, termOk;
  logic                     accept;

  // Seven-bit control codes become XGMII control characters; anything that
  // is not idle is reported as an error character.
  function automatic logic [7:0] mapCode(input logic [6:0] code);
    return (code == 7'h00) ? 8'h07 : 8'hFE;
  endfunction

  // A new block is only taken when no upper word is still waiting to go out.
  assign accept = bus.i_rx_valid && !upperPending_q;

  // In terminate blocks data byte Dn sits one byte above lane n.
  assign termData = {8'h00, bus.i_rxd[63:8]};

  // Every control-block format places code Cj at bit 8+7j, so one table serves all.
  always_comb begin
    codeIdle = '0;
    codeOk   = '0;
    for (int j = 0; j < 8; j++) begin
      codeIdle[j] = (bus.i_rxd[8+7*j +: 7] == 7'h00);
      codeOk[j]   = codeIdle[j] || (bus.i_rxd[8+7*j +: 7] == 7'h1E);
    end
  end

  // Identify terminate types and check that every code after the terminate is idle.
  always_comb begin
    isTerm   = 1'b1;
    termLane = 4'd0;
    case (bus.i_rxd[7:0])
      8'h87:   termLane = 4'd0;
      8'h99:   termLane = 4'd1;
      8'hAA:   termLane = 4'd2;
      8'hB4:   termLane = 4'd3;
      8'hCC:   termLane = 4'd4;
      8'hD2:   termLane = 4'd5;
      8'hE1:   termLane = 4'd6;
      8'hFF:   termLane = 4'd7;
      default: isTerm   = 1'b0;
    endcase
    termOk = isTerm;
    for (int j = 0; j < 8; j++) begin
      if ((j > int'(termLane)) && !codeIdle[j]) begin
        termOk = 1'b0;
      end
    end
  end

  // Classify the incoming block and build its eight decoded XGMII lanes.
  always_comb begin
    rType   = R_E;
    decData = {ERR_WORD, ERR_WORD};
    decCtl  = 8'hFF;
    if (bus.i_rx_header == 2'b01) begin
      rType   = R_D;
      decData = bus.i_rxd;
      decCtl  = 8'h00;
    end else if (bus.i_rx_header == 2'b10) begin
      case (bus.i_rxd[7:0])
        8'h1E: begin
          if (&codeOk) begin
            rType = R_C;
            for (int j = 0; j < 8; j++) begin
              decData[8*j +: 8] = mapCode(bus.i_rxd[8+7*j +: 7]);
            end
          end
        end
        8'h78: begin
          rType   = R_S;
          decData = {bus.i_rxd[63:8], 8'hFB};
          decCtl  = 8'h01;
        end
        8'h33: begin
          if (&codeIdle[3:0]) begin
            rType   = R_S;
            decData = {bus.i_rxd[63:40], 8'hFB, IDLE_WORD};
            decCtl  = 8'h1F;
          end
        end
        8'h4B: begin
          rType          = R_C;
          decData[31:0]  = {bus.i_rxd[31:8], (bus.i_rxd[35:32] == 4'h0) ? 8'h9C : 8'hFE};
          for (int j = 4; j < 8; j++) begin
            decData[8*j +: 8] = mapCode(bus.i_rxd[8+7*j +: 7]);
          end
          decCtl = 8'hF1;
        end
        default: begin
          if (termOk) begin
            rType = R_T;
            for (int i = 0; i < 8; i++) begin
              if (i < int'(termLane)) begin
                decData[8*i +: 8] = termData[8*i +: 8];
                decCtl[i]         = 1'b0;
              end else if (i == int'(termLane)) begin
                decData[8*i +: 8] = 8'hFD;
                decCtl[i]         = 1'b1;
              end else begin
                decData[8*i +: 8] = 8'h07;
                decCtl[i]         = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  // Receive state machine transition; an RX_E destination replaces the block with errors.
  always_comb begin
    state_d = RX_E;
    case (state_q)
      RX_D: begin
        if (rType == R_D)      state_d = RX_D;
        else if (rType == R_T) state_d = RX_T;
      end
      RX_E: begin
        if (rType == R_C)      state_d = RX_C;
        else if (rType == R_D) state_d = RX_D;
        else if (rType == R_T) state_d = RX_T;
      end
      default: begin
        if (rType == R_C)      state_d = RX_C;
        else if (rType == R_S) state_d = RX_D;
      end
    endcase
    outData_d = decData;
    outCtl_d  = decCtl;
    if (state_d == RX_E) begin
      outData_d = {ERR_WORD, ERR_WORD};
      outCtl_d  = 8'hFF;
    end
  end

  // Register the FSM, the two-word output sequence and the saturating error counter.
  always_ff @(posedge i_rxc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= RX_INIT;
      rxd_q          <= IDLE_WORD;
      rxctl_q        <= 4'hF;
      rxValid_q      <= 1'b0;
      upperRxd_q     <= IDLE_WORD;
      upperCtl_q     <= 4'hF;
      upperPending_q <= 1'b0;
      errCount_q     <= '0;
    end else begin
      rxValid_q      <= 1'b0;
      upperPending_q <= 1'b0;
      if (upperPending_q) begin
        rxd_q     <= upperRxd_q;
        rxctl_q   <= upperCtl_q;
        rxValid_q <= 1'b1;
      end else if (accept) begin
        rxValid_q      <= 1'b1;
        upperPending_q <= 1'b1;
        if (!bus.i_block_lock) begin
          rxd_q      <= LF_WORD;
          rxctl_q    <= 4'h1;
          upperRxd_q <= LF_WORD;
          upperCtl_q <= 4'h1;
        end else begin
          rxd_q      <= outData_d[31:0];
          rxctl_q    <= outCtl_d[3:0];
          upperRxd_q <= outData_d[63:32];
          upperCtl_q <= outCtl_d[7:4];
          state_q    <= state_d;
        end
      end
      if (!bus.i_block_lock) begin
        state_q <= RX_INIT;
      end
      if (bus.i_err_clear) begin
        errCount_q <= '0;
      end else if (accept && bus.i_block_lock && (state_d == RX_E) && (errCount_q != '1)) begin
        errCount_q <= errCount_q + 1'b1;
      end
    end
  end

  assign bus.o_rxd       = rxd_q;
  assign bus.o_rxctl     = rxctl_q;
  assign bus.o_rx_valid  = rxValid_q;
  assign bus.o_err_count = errCount_q;

endmodule

// File: tb/tb_decode_6466b.sv
// Directed bench for the 64b/66b receive decoder. A second instance with a
// two-bit error counter shares the same stimulus to exercise saturation.
module tb_decode_6466b;

  localparam logic [63:0] IDLE_BLK = 64'h0000_0000_0000_001E;
  localparam logic [31:0] IDLE_W   = 32'h0707_0707;
  localparam logic [31:0] ERR_W    = 32'hFEFE_FEFE;
  localparam logic [31:0] LF_W     = 32'h0100_009C;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  decode_6466b_if #(.ERR_CNT_WIDTH(16)) bus ();
  decode_6466b_if #(.ERR_CNT_WIDTH(2))  bus2 ();

  decode_6466b #(.ERR_CNT_WIDTH(16)) dut (
    .i_rxc     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  decode_6466b #(.ERR_CNT_WIDTH(2)) dut2 (
    .i_rxc     (clk),
    .i_reset_n (rst_n),
    .bus       (bus2)
  );

  // The small-counter instance mirrors every input of the main instance.
  assign bus2.i_block_lock = bus.i_block_lock;
  assign bus2.i_rx_valid   = bus.i_rx_valid;
  assign bus2.i_rxd        = bus.i_rxd;
  assign bus2.i_rx_header  = bus.i_rx_header;
  assign bus2.i_err_clear  = bus.i_err_clear;

  // Free-running receive clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present one block and capture the two words that follow it.
  task automatic applyStimulus(input logic [1:0] hdr, input logic [63:0] data,
                               output logic [36:0] lo, output logic [36:0] hi);
    @(negedge clk);
    bus.i_rx_valid  = 1'b1;
    bus.i_rx_header = hdr;
    bus.i_rxd       = data;
    @(posedge clk);
    #1;
    lo = {bus.o_rx_valid, bus.o_rxctl, bus.o_rxd};
    bus.i_rx_valid = 1'b0;
    @(posedge clk);
    #1;
    hi = {bus.o_rx_valid, bus.o_rxctl, bus.o_rxd};
  endtask

  // Send a block and check both output words including the valid flag.
  task automatic sendAndCheck(input string tag, input logic [1:0] hdr, input logic [63:0] data,
                              input logic [31:0] e0, input logic [3:0] c0,
                              input logic [31:0] e1, input logic [3:0] c1);
    logic [36:0] lo, hi;
    applyStimulus(hdr, data, lo, hi);
    checkOutput({tag, "/lo"}, {27'b0, lo}, {27'b0, 1'b1, c0, e0});
    checkOutput({tag, "/hi"}, {27'b0, hi}, {27'b0, 1'b1, c1, e1});
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [36:0] lo, hi;
    vectors     = 0;
    miscompares = 0;
    rst_n              = 1'b0;
    bus.i_block_lock   = 1'b1;
    bus.i_rx_valid     = 1'b0;
    bus.i_rxd          = '0;
    bus.i_rx_header    = 2'b00;
    bus.i_err_clear    = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("reset_rxd", {32'b0, bus.o_rxd}, {32'b0, IDLE_W});
    checkOutput("reset_ctl", {60'b0, bus.o_rxctl}, 64'hF);
    checkOutput("reset_valid", {63'b0, bus.o_rx_valid}, 64'h0);
    checkOutput("reset_cnt", {48'b0, bus.o_err_count}, 64'h0);
    rst_n = 1'b1;

    // 1: idle blocks
    sendAndCheck("idle1", 2'b10, IDLE_BLK, IDLE_W, 4'hF, IDLE_W, 4'hF);
    sendAndCheck("idle2", 2'b10, IDLE_BLK, IDLE_W, 4'hF, IDLE_W, 4'hF);
    checkOutput("idle_cnt", {48'b0, bus.o_err_count}, 64'h0);

    // 2: start / data / terminate-in-lane-3 frame
    sendAndCheck("start78", 2'b10, 64'h0706_0504_0302_0178, 32'h0302_01FB, 4'h1, 32'h0706_0504, 4'h0);
    sendAndCheck("data", 2'b01, 64'h0F0E_0D0C_0B0A_0908, 32'h0B0A_0908, 4'h0, 32'h0F0E_0D0C, 4'h0);
    sendAndCheck("termB4", 2'b10, 64'h0000_0000_1211_10B4, 32'hFD12_1110, 4'h8, IDLE_W, 4'hF);
    sendAndCheck("idle3", 2'b10, IDLE_BLK, IDLE_W, 4'hF, IDLE_W, 4'hF);

    // 3: protocol errors and recovery
    sendAndCheck("dataInC", 2'b01, 64'h1122_3344_5566_7788, ERR_W, 4'hF, ERR_W, 4'hF);
    checkOutput("cnt1", {48'b0, bus.o_err_count}, 64'd1);
    sendAndCheck("idleAfterE", 2'b10, IDLE_BLK, IDLE_W, 4'hF, IDLE_W, 4'hF);
    sendAndCheck("hdr00", 2'b00, IDLE_BLK, ERR_W, 4'hF, ERR_W, 4'hF);
    checkOutput("cnt2", {48'b0, bus.o_err_count}, 64'd2);
    sendAndCheck("dataFromE", 2'b01, 64'h8877_6655_4433_2211, 32'h4433_2211, 4'h0, 32'h8877_6655, 4'h0);
    sendAndCheck("term87", 2'b10, 64'h0000_0000_0000_0087, 32'h0707_07FD, 4'hF, IDLE_W, 4'hF);
    sendAndCheck("idle4", 2'b10, IDLE_BLK, IDLE_W, 4'hF, IDLE_W, 4'hF);
    sendAndCheck("start33", 2'b10, 64'hA7A6_A500_0000_0033, IDLE_W, 4'hF, 32'hA7A6_A5FB, 4'h1);
    sendAndCheck("termFF", 2'b10, 64'h0706_0504_0302_01FF, 32'h0403_0201, 4'h0, 32'hFD07_0605, 4'h8);
    sendAndCheck("idle5", 2'b10, IDLE_BLK, IDLE_W, 4'hF, IDLE_W, 4'hF);
    sendAndCheck("oset4B", 2'b10, 64'h0000_0000_0100_004B, 32'h0100_009C, 4'h1, IDLE_W, 4'hF);
    checkOutput("cnt2b", {48'b0, bus.o_err_count}, 64'd2);

    // 4: lock loss forces local fault, relock restarts decoding
    bus.i_block_lock = 1'b0;
    sendAndCheck("noLockIdle", 2'b10, IDLE_BLK, LF_W, 4'h1, LF_W, 4'h1);
    sendAndCheck("noLockData", 2'b01, 64'h1111_1111_1111_1111, LF_W, 4'h1, LF_W, 4'h1);
    checkOutput("noLockCnt", {48'b0, bus.o_err_count}, 64'd2);
    bus.i_block_lock = 1'b1;
    sendAndCheck("relockStart", 2'b10, 64'h0706_0504_0302_0178, 32'h0302_01FB, 4'h1, 32'h0706_0504, 4'h0);
    sendAndCheck("relockTerm", 2'b10, 64'h0000_0000_1211_10B4, 32'hFD12_1110, 4'h8, IDLE_W, 4'hF);
    sendAndCheck("idle6", 2'b10, IDLE_BLK, IDLE_W, 4'hF, IDLE_W, 4'hF);

    // 5: back-to-back valid, the second block must be dropped
    @(negedge clk);
    bus.i_rx_valid  = 1'b1;
    bus.i_rx_header = 2'b10;
    bus.i_rxd       = 64'h0706_0504_0302_0178;
    @(posedge clk);
    #1;
    checkOutput("b2b/lo", {27'b0, bus.o_rx_valid, bus.o_rxctl, bus.o_rxd}, {27'b0, 1'b1, 4'h1, 32'h0302_01FB});
    bus.i_rxd = IDLE_BLK;
    @(posedge clk);
    #1;
    checkOutput("b2b/hi", {27'b0, bus.o_rx_valid, bus.o_rxctl, bus.o_rxd}, {27'b0, 1'b1, 4'h0, 32'h0706_0504});
    bus.i_rx_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b2b/hold", {27'b0, bus.o_rx_valid, bus.o_rxctl, bus.o_rxd}, {27'b0, 1'b0, 4'h0, 32'h0706_0504});
    sendAndCheck("b2bData", 2'b01, 64'h0F0E_0D0C_0B0A_0908, 32'h0B0A_0908, 4'h0, 32'h0F0E_0D0C, 4'h0);
    sendAndCheck("b2bTerm", 2'b10, 64'h0000_0000_0000_0087, 32'h0707_07FD, 4'hF, IDLE_W, 4'hF);
    checkOutput("b2bCnt", {48'b0, bus.o_err_count}, 64'd2);

    // 6: counter clear and saturation
    @(negedge clk);
    bus.i_err_clear = 1'b1;
    @(negedge clk);
    bus.i_err_clear = 1'b0;
    checkOutput("clrCnt", {48'b0, bus.o_err_count}, 64'd0);
    checkOutput("clrCnt2", {62'b0, bus2.o_err_count}, 64'd0);
    sendAndCheck("hdr11", 2'b11, 64'h0, ERR_W, 4'hF, ERR_W, 4'hF);
    applyStimulus(2'b11, 64'h0, lo, hi);
    applyStimulus(2'b11, 64'h0, lo, hi);
    checkOutput("sat3", {62'b0, bus2.o_err_count}, 64'd3);
    applyStimulus(2'b11, 64'h0, lo, hi);
    applyStimulus(2'b11, 64'h0, lo, hi);
    checkOutput("sat5", {62'b0, bus2.o_err_count}, 64'd3);
    checkOutput("wide5", {48'b0, bus.o_err_count}, 64'd5);
    bus.i_err_clear = 1'b1;
    sendAndCheck("clrErr", 2'b11, 64'h0, ERR_W, 4'hF, ERR_W, 4'hF);
    bus.i_err_clear = 1'b0;
    checkOutput("clrWin", {48'b0, bus.o_err_count}, 64'd0);
    checkOutput("clrWin2", {62'b0, bus2.o_err_count}, 64'd0);
    sendAndCheck("idleEnd", 2'b10, IDLE_BLK, IDLE_W, 4'hF, IDLE_W, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
